// File: rtl/ysyx_24100006_axi_pkg.sv
// Shared AXI arbiter definitions: FSM states, response codes and master IDs.
// Used by the arbiter top and its pick sub-module.
package ysyx_24100006_axi_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/ysyx_24100006_arb_pick.sv
// Combinational two-requester pick: fixed priority (req1 wins) by default,
// round-robin against last_owner_i when ARB_RR_EN is defined.
module ysyx_24100006_arb_pick
    import ysyx_24100006_axi_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_owner_i,
    output logic grant_id_o,
    output logic grant_valid_o
);

    assign grant_valid_o = req0_i | req1_i;

`ifdef ARB_RR_EN
    // On contention the requester that was not served last wins.
    assign grant_id_o = (req0_i && req1_i) ? ~last_owner_i
                                           : (req1_i ? M_LSU : M_IFU);
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner_i;
    assign grant_id_o = req1_i ? M_LSU : M_IFU;
`endif

endmodule

// File: rtl/ysyx_24100006_axi_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI4 arbiter; one grant per
// transaction. Define ARB_RR_EN for round-robin between masters instead of fixed priority.
module ysyx_24100006_axi_arbiter
    import ysyx_24100006_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    // M0 (IFU) read
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rlast,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    // M1 (LSU) read
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rlast,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    // M1 (LSU) write
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [7:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    // Slave side
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rlast,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [7:0]          s_awlen,
    output logic [2:0]          s_awsize,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready
);

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   wr_req, req1, grant_id, grant_valid, last_owner;

    assign wr_req = m1_awvalid && m1_wvalid;
    assign req1   = wr_req || m1_arvalid;

    ysyx_24100006_arb_pick u_pick (
        .req0_i        (m0_arvalid),
        .req1_i        (req1),
        .last_owner_i  (last_owner),
        .grant_id_o    (grant_id),
        .grant_valid_o (grant_valid)
    );

`ifdef ARB_RR_EN
    logic last_owner_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_q <= M_IFU;
        end else if (state_q == S_IDLE && grant_valid) begin
            last_owner_q <= grant_id;
        end
    end
    assign last_owner = last_owner_q;
`else
    assign last_owner = M_IFU;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            S_IDLE: if (grant_valid) begin
                owner_d = grant_id;
                // Inside M1 a write always beats a read.
                state_d = (grant_id == M_LSU && wr_req) ? S_WR : S_RD;
            end
            S_RD: if (s_rvalid && s_rready && s_rlast) state_d = S_IDLE;
            S_WR: if (s_bvalid && m1_bready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= M_IFU;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    logic rd0, rd1, wr_act;
    assign rd0    = (state_q == S_RD) && (owner_q == M_IFU);
    assign rd1    = (state_q == S_RD) && (owner_q == M_LSU);
    assign wr_act = (state_q == S_WR);

    // Read routing; unrouted buses are driven 0.
    assign s_araddr   = rd0 ? m0_araddr : (rd1 ? m1_araddr : '0);
    assign s_arlen    = rd0 ? m0_arlen  : (rd1 ? m1_arlen  : '0);
    assign s_arsize   = rd0 ? m0_arsize : (rd1 ? m1_arsize : '0);
    assign s_arvalid  = (rd0 && m0_arvalid) || (rd1 && m1_arvalid);
    assign m0_arready = rd0 && s_arready;
    assign m1_arready = rd1 && s_arready;
    assign s_rready   = (rd0 && m0_rready) || (rd1 && m1_rready);

    assign m0_rdata  = rd0 ? s_rdata : '0;
    assign m0_rresp  = rd0 ? s_rresp : '0;
    assign m0_rlast  = rd0 && s_rlast;
    assign m0_rvalid = rd0 && s_rvalid;
    assign m1_rdata  = rd1 ? s_rdata : '0;
    assign m1_rresp  = rd1 ? s_rresp : '0;
    assign m1_rlast  = rd1 && s_rlast;
    assign m1_rvalid = rd1 && s_rvalid;

    // Write routing (M1 only)
    assign s_awaddr   = wr_act ? m1_awaddr : '0;
    assign s_awlen    = wr_act ? m1_awlen  : '0;
    assign s_awsize   = wr_act ? m1_awsize : '0;
    assign s_awvalid  = wr_act && m1_awvalid;
    assign m1_awready = wr_act && s_awready;
    assign s_wdata    = wr_act ? m1_wdata : '0;
    assign s_wstrb    = wr_act ? m1_wstrb : '0;
    assign s_wlast    = wr_act && m1_wlast;
    assign s_wvalid   = wr_act && m1_wvalid;
    assign m1_wready  = wr_act && s_wready;
    assign m1_bresp   = wr_act ? s_bresp : '0;
    assign m1_bvalid  = wr_act && s_bvalid;
    assign s_bready   = wr_act && m1_bready;

    // A slave response with no transaction outstanding is a protocol error.
    assert property (@(posedge clk) disable iff (reset)
        (state_q == S_IDLE) |-> !(s_rvalid || s_bvalid));

endmodule

// File: doc/ysyx_24100006_axi_arbiter.md
# ysyx_24100006_axi_arbiter

Two-master, one-slave AXI4 arbiter between the core's fetch unit (M0, IFU, read-only) and load/store unit (M1, LSU, read/write) and the shared memory slave (AXI memory model / SoC port). It grants the slave to exactly one master per transaction, holds the grant for the whole burst or write, and routes all channels so that neither master ever sees the other's handshakes.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (wstrb = DATA_W/8)

Ports. Each bullet covers one AXI channel; the listed signals carry the usual AXI4 direction and width.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- m0_ar*  in/out  araddr[ADDR_W], arlen[8], arsize[3], arvalid in; arready out. IFU read address.
- m0_r*  out/in  rdata[DATA_W], rresp[2], rlast, rvalid out; rready in. IFU read data.
- m1_ar*, m1_r*  same as M0. LSU read.
- m1_aw*  in/out  awaddr, awlen, awsize, awvalid in; awready out. LSU write address.
- m1_w*  in/out  wdata, wstrb, wlast, wvalid in; wready out. LSU write data.
- m1_b*  out/in  bresp[2], bvalid out; bready in. LSU write response.
- s_*  mirror of all of the above toward the slave (ar/r/aw/w/b); master-side outputs become slave-side inputs and vice versa.

## Operation
- The FSM has three states: S_IDLE, S_RD, S_WR. A 1-bit owner register (0 = M0, 1 = M1) goes with the state.
- The arbiter stays in S_IDLE until it sees a request, then grants it:
  - A M1 write request is m1_awvalid && m1_wvalid. It goes to S_WR with owner = 1.
  - A read request is mX_arvalid. It goes to S_RD with owner = X.
  - Fixed priority: M1 write > M1 read > M0 read.
  - A request that arrives in S_IDLE is granted on the next edge. No channel is routed while the FSM is in S_IDLE.
- Behaviour in S_RD:
  - Routing is combinational: owner's AR → s_ar, and s_r → owner's R.
  - The exit condition is s_rvalid && m_rready(owner) && s_rlast; the FSM then returns to S_IDLE.
  - Burst length is the slave's concern. The arbiter only watches rlast.
- Behaviour in S_WR:
  - M1's AW, W and B channels are routed straight through.
  - The exit condition is s_bvalid && m1_bready; the FSM then returns to S_IDLE.
- Blocking:
  - The non-owner master sees ready = 0 and valid = 0 on every channel.
  - All s_*valid and m*_*ready outputs are 0 in S_IDLE.
  - Requests that are not granted stay pending, and their valids must remain held by the masters.
- Data outputs when not routed: ungated data buses are don't-care, but they are driven 0 to keep waveforms clean.
- A slave response that arrives in S_IDLE is ignored. This is a protocol error, and an assertion flags it in simulation.
- The arbiter holds no address or data storage. Throughput is one transaction per (transaction + 1 idle cycle).

## Timing
- Reset: state = S_IDLE, owner = 0, RR pointer = 0. Every valid and ready output is 0 in the cycle after reset is sampled.
- Reset mid-transaction: the FSM drops to S_IDLE immediately and routing stops. The slave and masters are reset by the same signal.
- Grant latency: 1 cycle from request to a visible s_arvalid / s_awvalid.
- Release latency: after the final handshake (rlast beat or B), the next grant's valid appears 2 cycles later. The FSM spends 1 cycle in S_IDLE.
- Simultaneous M0 and M1 read requests: priority decides (see Configuration). The loser waits without loss.
- M1 arvalid and write request together: the write wins. The read is served after bvalid handshakes.

## Configuration
- ARB_RR_EN defined:
  - M0 and M1 requests are arbitrated round-robin. A 1-bit last_owner register is updated on each grant.
  - On contention, the master that was not last served wins.
  - Inside M1, write still beats read.
- ARB_RR_EN undefined: fixed priority as described above, and no last_owner register is built.

## Structure
- Shared package ysyx_24100006_axi_pkg holds:
  - state localparams (S_IDLE/S_RD/S_WR)
  - AXI resp codes (OKAY = 2'b00, SLVERR = 2'b10)
  - owner IDs M_IFU = 0, M_LSU = 1
- Sub-module: ysyx_24100006_arb_pick. It is a combinational priority/RR pick that takes (req0, req1, last_owner) and returns (grant_id, grant_valid). It is reused by the future SoC crossbar.
- The top module holds the FSM and the channel muxes.

## Test plan
- Single M0 read, araddr = 0x8000_0000, arlen = 0 → s_araddr = 0x8000_0000 one cycle after the request. m0 gets rdata with rlast = 1, then S_IDLE.
- M0 burst, arlen = 3, at 0x8000_0010 → m0 receives 4 beats. rlast only on beat 4. m1_rvalid stays 0 throughout.
- M1 write, 0x8000_0100, wdata = 0xDEADBEEF, wstrb = 4'b0011 → slave sees identical aw/w. m1_bresp = 00, and M0 is blocked until the B handshake.
- M0 and M1 reads asserted in the same cycle:
  - Without ARB_RR_EN: M1 is served first in both back-to-back rounds.
  - With ARB_RR_EN: grants alternate M1, M0, M1.
- reset asserted mid-burst (beat 2 of 4) → all valid/ready outputs are 0 next cycle. A new M0 read after reset completes normally.
- Stall: m0_rready held 0 for 5 cycles during a burst → s_rready = 0 and no beat is lost. Grant is held until rlast.
